branch_resolver: RTL

Sits between the fetch stage and the two-level branch predictor. Fetch asks this block for a prediction; it drives the predictor's request line, queues the predicted direction in order, and when execute resolves the branch it compares actual against predicted. It then feeds the outcome back to the predictor's `result`/`result_strob` training inputs and raises a one-cycle `flush` on a misprediction.

---
 rtl/branch_resolver.sv | 131 +++++++++++++
 1 files changed

// File: rtl/branch_resolver.sv
// branch_resolver
//   Sits between fetch and the two-level branch predictor. Forwards fetch
//   prediction requests to the predictor and keeps the predicted directions
//   in order in a small circular queue. When execute resolves the oldest
//   branch, the block compares the actual direction with the predicted one.
//   It then trains the predictor through result/result_strob and raises a
//   one-cycle flush on a misprediction.
//
//   Optional feature macro: BRANCH_RESOLVER_STATS_EN
//     defined   -> saturating stat_total / stat_miss counters are built
//     undefined -> stat_total / stat_miss are tied to 0
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   br_issue          fetch wants a prediction this cycle
//   issue_ready       queue not full
//   predict_req       request to predictor (combinational)
//   predict           predictor direction, valid while predict_req=1
//   pred_taken        predict forwarded to fetch, 0 when no request
//   exec_valid        execute resolves the oldest outstanding branch
//   exec_taken        actual direction of that branch
//   result            registered actual direction to predictor
//   result_strob      registered one-cycle training strobe
//   flush             registered one-cycle mispredict flush
//   level             queue occupancy, 0..DEPTH
//   underflow         sticky: resolve seen with an empty queue
//   stat_total        resolved branch count (saturating)
//   stat_miss         mispredicted branch count (saturating)
`timescale 1ns/1ps

module branch_resolver #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     br_issue,
  output logic                     issue_ready,
  output logic                     predict_req,
  input  logic                     predict,
  output logic                     pred_taken,
  input  logic                     exec_valid,
  input  logic                     exec_taken,
  output logic                     result,
  output logic                     result_strob,
  output logic                     flush,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     underflow,
  output logic [CNT_W-1:0]         stat_total,
  output logic [CNT_W-1:0]         stat_miss
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [DEPTH-1:0] q;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             head, nonempty, pop, push, mispredict_now;

  assign nonempty       = (level != '0);
  assign issue_ready    = (level != LW'(DEPTH));
  assign head           = q[rd_ptr];
  assign pop            = exec_valid & nonempty;
  assign mispredict_now = pop & (head != exec_taken);
  // An issue in a mispredict cycle is on the wrong path, so it is dropped.
  assign predict_req    = br_issue & issue_ready & ~mispredict_now;
  assign push           = predict_req;
  // predict may float when it is not requested, so gate it off.
  assign pred_taken     = predict_req & predict;

  // Queue, pointers and occupancy. DEPTH is a power of two, so the
  // pointers wrap naturally at PW bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q      <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) q[wr_ptr] <= predict;
      if (mispredict_now) begin
        // Everything younger than the mispredicted branch is wrong-path.
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   level <= level + LW'(1);
          2'b01:   level <= level - LW'(1);
          default: level <= level;
        endcase
      end
    end
  end

  // Training and flush outputs, one cycle after the resolving edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result       <= 1'b0;
      result_strob <= 1'b0;
      flush        <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      result_strob <= pop;
      flush        <= mispredict_now;
      if (pop) result <= exec_taken;
      if (exec_valid & ~nonempty) underflow <= 1'b1;
    end
  end

`ifdef BRANCH_RESOLVER_STATS_EN
  // Saturating counters: they hold at all-ones and do not wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_total <= '0;
      stat_miss  <= '0;
    end else begin
      if (pop && (stat_total != '1))
        stat_total <= stat_total + CNT_W'(1);
      if (mispredict_now && (stat_miss != '1))
        stat_miss <= stat_miss + CNT_W'(1);
    end
  end
`else
  assign stat_total = '0;
  assign stat_miss  = '0;
`endif

endmodule
